// File: rtl/mips_cpu_instr_memory.sv
// Instruction memory for the Harvard CPU fetch port: wiped on reset, filled over a
// byte-serial load port, then serves zero-latency byte-swapped fetches.
module mips_cpu_instr_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 64,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_enable,
  input  logic          load_valid,
  input  logic [7:0]    load_byte,
  input  logic          load_last,
  output logic          load_ready,
  output logic          program_ready,
  output logic          overflow,
  output logic [AW:0]   word_count,
  input  logic [31:0]   instr_address,
  output logic [31:0]   instr_readdata
);

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH_WORDS - 1);
  localparam logic [31:0]   SPAN       = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic [AW-1:0] wr_ptr;
  logic [1:0]    byte_cnt;
  logic [23:0]   shift;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          full;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   off;
  logic          hit;
  logic [AW-1:0] idx;

  // Place the incoming byte after the bytes already gathered; unused low bytes stay 0.
  function automatic logic [31:0] pad_word(input logic [23:0] prev, input logic [7:0] b,
                                           input logic [1:0] cnt);
    case (cnt)
      2'd0:    return {b, 24'h0};
      2'd1:    return {prev[7:0], b, 16'h0};
      2'd2:    return {prev[15:0], b, 8'h0};
      default: return {prev, b};
    endcase
  endfunction

  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign load_ready    = (state == LOAD) && clk_enable;
  assign program_ready = (state == RUN);
  assign accept        = load_ready && load_valid;
  assign full          = (word_count == FULL_COUNT);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wr_ptr;
    mem_wdata = pad_word(shift, load_byte, byte_cnt);
    if (reset && clk_enable) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr;
        mem_wdata = 32'h0;
      end else if (accept && !full && (byte_cnt == 2'd3 || load_last)) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= CLEAR;
      clr_ptr    <= '0;
      wr_ptr     <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else if (clk_enable) begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_IDX) state <= LOAD;
        end
        LOAD: begin
          if (load_valid) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              shift    <= {shift[15:0], load_byte};
              byte_cnt <= byte_cnt + 1'b1;
              if (byte_cnt == 2'd3 || load_last) begin
                wr_ptr     <= wr_ptr + 1'b1;
                word_count <= word_count + 1'b1;
                byte_cnt   <= '0;
              end
            end
            if (load_last) state <= RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // Underflowed offsets are rejected by the lower-bound compare, so no window wrap.
  assign off            = instr_address - BASE_ADDR;
  assign hit            = (instr_address[1:0] == 2'b00) && (instr_address >= BASE_ADDR) &&
                          (off < SPAN);
  assign idx            = off[AW+1:2];
  assign instr_readdata = hit ? swap_bytes(mem[idx]) : 32'h0;

endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
// Directed bench for mips_cpu_instr_memory: a 64-word instance and a 4-word instance.
module tb_mips_cpu_instr_memory;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clk_enable, load_valid, load_last;
  logic [7:0]  load_byte;
  logic        load_ready, program_ready, overflow;
  logic [6:0]  word_count;
  logic [31:0] instr_address, instr_readdata;

  logic        reset4, clk_enable4, load_valid4, load_last4;
  logic [7:0]  load_byte4;
  logic        load_ready4, program_ready4, overflow4;
  logic [2:0]  word_count4;
  logic [31:0] instr_address4, instr_readdata4;

  int checks = 0;
  int errors = 0;

  mips_cpu_instr_memory dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .load_valid(load_valid),
    .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready),
    .program_ready(program_ready), .overflow(overflow), .word_count(word_count),
    .instr_address(instr_address), .instr_readdata(instr_readdata)
  );

  mips_cpu_instr_memory #(.DEPTH_WORDS(4)) dut4 (
    .clk(clk), .reset(reset4), .clk_enable(clk_enable4), .load_valid(load_valid4),
    .load_byte(load_byte4), .load_last(load_last4), .load_ready(load_ready4),
    .program_ready(program_ready4), .overflow(overflow4), .word_count(word_count4),
    .instr_address(instr_address4), .instr_readdata(instr_readdata4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    instr_address = addr;
    #1;
    chk(tag, instr_readdata, exp);
  endtask

  task automatic fetch4(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    instr_address4 = addr;
    #1;
    chk(tag, instr_readdata4, exp);
  endtask

  // Offers one byte for one clock; called just after a falling edge.
  task automatic send(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b, input logic last);
    load_valid4 = 1'b1;
    load_byte4  = b;
    load_last4  = last;
    @(negedge clk);
    load_valid4 = 1'b0;
    load_last4  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; clk_enable = 1'b1; load_valid = 1'b0; load_last = 1'b0;
    load_byte = 8'h00; instr_address = BASE;
    reset4 = 1'b0; clk_enable4 = 1'b1; load_valid4 = 1'b0; load_last4 = 1'b0;
    load_byte4 = 8'h00; instr_address4 = BASE;

    // Reset state
    cycles(2);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_program_ready", program_ready, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_overflow", overflow, 0);

    // CLEAR lasts exactly 64 enabled cycles
    reset = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 1 || k == 63 || k == 64) begin
        chk($sformatf("clear_load_ready_%0d", k), load_ready, (k == 64) ? 1 : 0);
        fetch($sformatf("clear_fetch_%0d", k), BASE, 32'h0);
      end
    end

    // Two-word boot image
    send(8'h0B, 0); send(8'hF0, 0); send(8'h00, 0); send(8'h04, 0);
    send(8'h24, 0); send(8'h00, 0); send(8'h00, 0);
    fetch("pre_last_word1", BASE + 4, 32'h0);
    send(8'h00, 1);
    chk("img_word_count", word_count, 2);
    chk("img_program_ready", program_ready, 1);
    chk("img_load_ready", load_ready, 0);
    fetch("img_word0", BASE, 32'h0400F00B);
    fetch("img_word1", BASE + 4, 32'h00000024);

    // Misses
    fetch("miss_zero", 32'h00000000, 32'h0);
    fetch("miss_misaligned", 32'hBFC00002, 32'h0);
    fetch("miss_above", 32'hBFC00100, 32'h0);
    fetch("miss_below", 32'hBFBFFFFC, 32'h0);

    // Loads in RUN are ignored
    send(8'h55, 1);
    chk("run_ignore_count", word_count, 2);
    fetch("run_ignore_word2", BASE + 8, 32'h0);

    // Reset from RUN wipes the image
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    chk("rerun_program_ready", program_ready, 0);
    cycles(64);
    chk("rerun_load_ready", load_ready, 1);
    fetch("rerun_wiped0", BASE, 32'h0);

    // Reset mid-load after 6 bytes
    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0);
    send(8'hA4, 0); send(8'hA5, 0); send(8'hA6, 0);
    chk("midload_word_count", word_count, 1);
    fetch("midload_word0", BASE, 32'hA4A3A2A1);
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    chk("midload_rst_count", word_count, 0);
    chk("midload_rst_ready", load_ready, 0);
    cycles(64);
    fetch("midload_wiped0", BASE, 32'h0);

    // Partial last word with a clk_enable freeze in the middle
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    clk_enable = 1'b0;
    load_valid = 1'b1;
    load_byte  = 8'h99;
    load_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("freeze_load_ready_%0d", k), load_ready, 0);
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    clk_enable = 1'b1;
    chk("freeze_word_count", word_count, 0);
    chk("freeze_program_ready", program_ready, 0);
    send(8'h44, 0);
    send(8'h10, 1);
    chk("partial_word_count", word_count, 2);
    chk("partial_program_ready", program_ready, 1);
    fetch("partial_word0", BASE, 32'h44332211);
    fetch("partial_word1", BASE + 4, 32'h00000010);

    // Four-word instance overflow
    reset4 = 1'b1;
    cycles(3);
    chk("d4_clear_ready3", load_ready4, 0);
    cycles(1);
    chk("d4_clear_ready4", load_ready4, 1);
    for (int i = 0; i < 20; i++) begin
      if (i == 19) chk("d4_ready_when_full", load_ready4, 1);
      send4(8'(i + 1), (i == 19) ? 1'b1 : 1'b0);
    end
    chk("d4_word_count", word_count4, 4);
    chk("d4_overflow", overflow4, 1);
    chk("d4_program_ready", program_ready4, 1);
    fetch4("d4_word0", BASE, 32'h04030201);
    fetch4("d4_word1", BASE + 4, 32'h08070605);
    fetch4("d4_word2", BASE + 8, 32'h0C0B0A09);
    fetch4("d4_word3", BASE + 12, 32'h100F0E0D);
    fetch4("d4_no_wrap", BASE + 16, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
